// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the serial-command system controller: command bytes,
// FSM state encoding and the fixed register-file addresses for ALU operands.
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_SEND,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_SEND_LO,
    ST_SEND_HI
  } state_t;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  // The ALU clock is only needed from function fetch until the result is sent.
  function automatic logic is_alu_state(input state_t s);
    return s inside {ST_ALU_FUN, ST_ALU_WAIT, ST_SEND_LO, ST_SEND_HI};
  endfunction

endpackage

// File: rtl/sys_ctrl.sv
// Byte-stream command decoder driving register-file, ALU and TX FIFO accesses.
// All strobes and data outputs are registered; clk_div_en is permanently on.
//
// state       | meaning
// ST_IDLE     | waiting for a command byte
// ST_WR_ADDR  | RF write: collect address byte
// ST_WR_DATA  | RF write: collect data byte, issue write
// ST_RD_ADDR  | RF read: collect address byte, issue read
// ST_RD_WAIT  | RF read: wait for rf_rd_valid
// ST_RD_SEND  | RF read: push read byte to TX
// ST_OP_A     | ALU: collect operand A, write to RF addr 0
// ST_OP_B     | ALU: collect operand B, write to RF addr 1
// ST_ALU_FUN  | ALU: collect function code, start ALU
// ST_ALU_WAIT | ALU: wait for alu_valid
// ST_SEND_LO  | ALU: push result low byte
// ST_SEND_HI  | ALU: push result high byte
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  input  logic                    fifo_full,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    alu_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  output logic                    clk_div_en
);

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;
  logic                    rf_wr_en_d, rf_rd_en_d, alu_en_d, tx_valid_d;

  assign clk_div_en = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      rf_addr     <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      rf_addr     <= rf_addr_d;
      rf_wr_en    <= rf_wr_en_d;
      rf_rd_en    <= rf_rd_en_d;
      rf_wr_data  <= rf_wr_data_d;
      alu_en      <= alu_en_d;
      alu_fun     <= alu_fun_d;
      clk_gate_en <= is_alu_state(state_d);
      tx_data     <= tx_data_d;
      tx_valid    <= tx_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    rf_addr_d    = rf_addr;
    rf_wr_data_d = rf_wr_data;
    alu_fun_d    = alu_fun;
    tx_data_d    = tx_data;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: if (rx_valid) begin
        if      (rx_data == DATA_WIDTH'(CMD_RF_WR))   state_d = ST_WR_ADDR;
        else if (rx_data == DATA_WIDTH'(CMD_RF_RD))   state_d = ST_RD_ADDR;
        else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_OP_A;
        else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_ALU_FUN;
      end
      ST_WR_ADDR: if (rx_valid) begin
        rf_addr_d = rx_data[ADDR_WIDTH-1:0];
        state_d   = ST_WR_DATA;
      end
      ST_WR_DATA: if (rx_valid) begin
        rf_wr_data_d = rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RD_ADDR: if (rx_valid) begin
        rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (rf_rd_valid) begin
        result_d = {{DATA_WIDTH{1'b0}}, rf_rd_data};
        state_d  = ST_RD_SEND;
      end
      // tx_data is loaded together with tx_valid so each push carries its own byte.
      ST_RD_SEND: if (!fifo_full) begin
        tx_data_d  = result_q[DATA_WIDTH-1:0];
        tx_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_OP_A: if (rx_valid) begin
        rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
        rf_wr_data_d = rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_OP_B;
      end
      ST_OP_B: if (rx_valid) begin
        rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
        rf_wr_data_d = rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_ALU_FUN;
      end
      ST_ALU_FUN: if (rx_valid) begin
        alu_fun_d = rx_data[FUN_WIDTH-1:0];
        alu_en_d  = 1'b1;
        state_d   = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (alu_valid) begin
        result_d = alu_out;
        state_d  = ST_SEND_LO;
      end
      ST_SEND_LO: if (!fifo_full) begin
        tx_data_d  = result_q[DATA_WIDTH-1:0];
        tx_valid_d = 1'b1;
        state_d    = ST_SEND_HI;
      end
      ST_SEND_HI: if (!fifo_full) begin
        tx_data_d  = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        tx_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Self-checking bench for sys_ctrl: directed command scenarios plus randomized
// command streams checked against a transaction-level model of RF, ALU and TX.
module tb_sys_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rf_rd_data = '0;
  logic          rf_rd_valid = 1'b0;
  logic [2*DW-1:0] alu_out = '0;
  logic          alu_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic [AW-1:0] rf_addr;
  logic          rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_valid, clk_div_en;
  logic [DW-1:0] rf_wr_data, tx_data;
  logic [FW-1:0] alu_fun;
  logic [28:0]   outs_all;

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_out(alu_out), .alu_valid(alu_valid), .fifo_full(fifo_full),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .clk_div_en(clk_div_en)
  );

  always #5 clk = ~clk;

  assign outs_all = {rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun,
                     clk_gate_en, tx_data, tx_valid};

  int n_checks = 0;
  int n_pass   = 0;
  int both_viol = 0;
  int full_viol = 0;
  logic full_last = 1'b0;

  logic [DW-1:0]    mem [16];
  logic [AW+DW-1:0] got_wr[$], exp_wr[$];
  logic [AW-1:0]    got_rd[$], exp_rd[$];
  logic [FW-1:0]    got_alu[$], exp_alu[$];
  logic [DW-1:0]    got_tx[$], exp_tx[$];

  // Observed events; fifo_full is only changed just after a rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr_en) got_wr.push_back({rf_addr, rf_wr_data});
      if (rf_rd_en) got_rd.push_back(rf_addr);
      if (alu_en)   got_alu.push_back(alu_fun);
      if (tx_valid) got_tx.push_back(tx_data);
      if (rf_wr_en && rf_rd_en) both_viol++;
      if (tx_valid && full_last) full_viol++;
    end
    full_last = fifo_full;
  end

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f[1:0])
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic clear_q();
    got_wr.delete(); exp_wr.delete(); got_rd.delete(); exp_rd.delete();
    got_alu.delete(); exp_alu.delete(); got_tx.delete(); exp_tx.delete();
  endtask

  task automatic respond_read(input logic [7:0] d);
    int t = 0;
    while (!rf_rd_en && t < 20) begin tick(); t++; end
    n_checks++;
    if (rf_rd_en !== 1'b1) $display("FAIL rd_en_timeout: rf_rd_en=%0b required 1", rf_rd_en);
    else n_pass++;
    repeat (2) tick();
    rf_rd_data  = d;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'($urandom);
  endtask

  task automatic respond_alu(input logic [15:0] r, input int delay);
    int t = 0;
    while (!alu_en && t < 20) begin tick(); t++; end
    n_checks++;
    if (alu_en !== 1'b1) $display("FAIL alu_en_timeout: alu_en=%0b required 1", alu_en);
    else n_pass++;
    repeat (delay) tick();
    n_checks++;
    if (clk_gate_en !== 1'b1) $display("FAIL gate_in_alu_wait: clk_gate_en=%0b required 1", clk_gate_en);
    else n_pass++;
    alu_out   = r;
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    alu_out   = 16'($urandom);
  endtask

  task automatic wait_tx(input int n, input bit rand_full);
    int t = 0;
    while (got_tx.size() < n && t < 200) begin
      if (rand_full) fifo_full = ($urandom_range(0, 2) == 0);
      tick();
      t++;
    end
    fifo_full = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (outs_all !== '0) $display("FAIL reset_outputs: got %h required 0", outs_all);
    else n_pass++;
    n_checks++;
    if (clk_div_en !== 1'b1) $display("FAIL reset_clk_div_en: got %0b required 1", clk_div_en);
    else n_pass++;
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (outs_all !== '0) $display("FAIL idle_outputs: got %h required 0", outs_all);
    else n_pass++;
  endtask

  task automatic test_write();
    clear_q();
    send_byte(8'hAA, 1); send_byte(8'h05, 1); send_byte(8'h3C, 1);
    repeat (3) tick();
    mem[5] = 8'h3C;
    n_checks++;
    if (got_wr.size() != 1) $display("FAIL write_count: got %0d required 1", got_wr.size());
    else n_pass++;
    n_checks++;
    if (((got_wr.size() > 0) ? got_wr[0] : 'x) !== 12'h53C)
      $display("FAIL write_addr_data: got %h required 53c", (got_wr.size() > 0) ? got_wr[0] : 'x);
    else n_pass++;
    n_checks++;
    if (got_rd.size() + got_tx.size() + got_alu.size() != 0)
      $display("FAIL write_side_effects: got %0d events required 0",
               got_rd.size() + got_tx.size() + got_alu.size());
    else n_pass++;
  endtask

  task automatic test_read();
    clear_q();
    send_byte(8'hBB, 1); send_byte(8'h05, 0);
    n_checks++;
    if (clk_gate_en !== 1'b0) $display("FAIL gate_in_read: clk_gate_en=%0b required 0", clk_gate_en);
    else n_pass++;
    respond_read(mem[5]);
    wait_tx(1, 0);
    n_checks++;
    if (got_rd.size() != 1 || got_rd[0] !== 4'h5)
      $display("FAIL read_request: got %0d reqs first %h required 1 req 5", got_rd.size(),
               (got_rd.size() > 0) ? got_rd[0] : 'x);
    else n_pass++;
    n_checks++;
    if (got_tx.size() != 1 || got_tx[0] !== 8'h3C)
      $display("FAIL read_tx: got %0d bytes first %h required 1 byte 3c", got_tx.size(),
               (got_tx.size() > 0) ? got_tx[0] : 'x);
    else n_pass++;
  endtask

  task automatic test_alu_op();
    logic [15:0] r;
    clear_q();
    send_byte(8'hCC, 1); send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h00, 0);
    mem[0] = 8'h10; mem[1] = 8'h20;
    r = alu_fn(mem[0], mem[1], 4'h0);
    respond_alu(r, 2);
    wait_tx(2, 0);
    n_checks++;
    if (got_wr.size() != 2 || got_wr[0] !== 12'h010 || got_wr[1] !== 12'h120)
      $display("FAIL alu_operand_writes: got %0d writes %h %h required 010 120", got_wr.size(),
               (got_wr.size() > 0) ? got_wr[0] : 'x, (got_wr.size() > 1) ? got_wr[1] : 'x);
    else n_pass++;
    n_checks++;
    if (got_alu.size() != 1 || got_alu[0] !== 4'h0)
      $display("FAIL alu_start: got %0d pulses fun %h required 1 pulse fun 0", got_alu.size(),
               (got_alu.size() > 0) ? got_alu[0] : 'x);
    else n_pass++;
    n_checks++;
    if (got_tx.size() != 2 || got_tx[0] !== 8'h30 || got_tx[1] !== 8'h00)
      $display("FAIL alu_tx: got %0d bytes %h %h required 30 00", got_tx.size(),
               (got_tx.size() > 0) ? got_tx[0] : 'x, (got_tx.size() > 1) ? got_tx[1] : 'x);
    else n_pass++;
    n_checks++;
    if (clk_gate_en !== 1'b0) $display("FAIL gate_after_alu: clk_gate_en=%0b required 0", clk_gate_en);
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    logic [15:0] r;
    logic [7:0]  held;
    clear_q();
    send_byte(8'hDD, 1); send_byte(8'h02, 0);
    r = alu_fn(mem[0], mem[1], 4'h2);
    fifo_full = 1'b1;
    respond_alu(r, 1);
    held = tx_data;
    repeat (5) tick();
    n_checks++;
    if (got_tx.size() != 0 || tx_valid !== 1'b0)
      $display("FAIL push_while_full: got %0d pushes tx_valid=%0b required 0 0", got_tx.size(), tx_valid);
    else n_pass++;
    n_checks++;
    if (tx_data !== held) $display("FAIL tx_data_hold: got %h required %h", tx_data, held);
    else n_pass++;
    fifo_full = 1'b0;
    wait_tx(2, 0);
    n_checks++;
    if (got_tx.size() != 2 || got_tx[0] !== r[7:0] || got_tx[1] !== r[15:8])
      $display("FAIL full_release_tx: got %0d bytes %h %h required %h %h", got_tx.size(),
               (got_tx.size() > 0) ? got_tx[0] : 'x, (got_tx.size() > 1) ? got_tx[1] : 'x,
               r[7:0], r[15:8]);
    else n_pass++;
  endtask

  task automatic test_invalid();
    clear_q();
    send_byte(8'h55, 1);
    repeat (4) tick();
    n_checks++;
    if (got_wr.size() + got_rd.size() + got_alu.size() + got_tx.size() != 0)
      $display("FAIL invalid_cmd_activity: got %0d events required 0",
               got_wr.size() + got_rd.size() + got_alu.size() + got_tx.size());
    else n_pass++;
    send_byte(8'hAA, 1); send_byte(8'h01, 1); send_byte(8'hFF, 1);
    repeat (3) tick();
    mem[1] = 8'hFF;
    n_checks++;
    if (got_wr.size() != 1 || got_wr[0] !== 12'h1FF)
      $display("FAIL write_after_invalid: got %0d writes %h required 1ff", got_wr.size(),
               (got_wr.size() > 0) ? got_wr[0] : 'x);
    else n_pass++;
  endtask

  task automatic test_drop();
    logic [15:0] r;
    int t = 0;
    clear_q();
    send_byte(8'hDD, 1); send_byte(8'h01, 0);
    while (!alu_en && t < 20) begin tick(); t++; end
    send_byte(8'hAA, 0); send_byte(8'h07, 0);
    r = alu_fn(mem[0], mem[1], 4'h1);
    alu_out = r; alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    send_byte(8'hBB, 0);
    wait_tx(2, 0);
    send_byte(8'h3C, 1);
    repeat (3) tick();
    n_checks++;
    if (got_wr.size() + got_rd.size() != 0)
      $display("FAIL dropped_bytes_used: got %0d rf accesses required 0", got_wr.size() + got_rd.size());
    else n_pass++;
    n_checks++;
    if (got_tx.size() != 2 || got_tx[0] !== r[7:0] || got_tx[1] !== r[15:8])
      $display("FAIL drop_alu_tx: got %0d bytes required %h %h", got_tx.size(), r[7:0], r[15:8]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_byte(8'hAA, 1); send_byte(8'h07, 1);
    rst = 1'b1;
    tick();
    n_checks++;
    if (outs_all !== '0 || clk_div_en !== 1'b1)
      $display("FAIL mid_reset_outputs: got %h div %0b required 0 div 1", outs_all, clk_div_en);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h3C, 1);
    repeat (3) tick();
    n_checks++;
    if (got_wr.size() != 0 || outs_all !== '0)
      $display("FAIL abandoned_write: got %0d writes outs %h required 0 0", got_wr.size(), outs_all);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a, b;
    logic [15:0] r;
    clear_q();
    a = 8'($urandom); b = 8'($urandom);
    send_byte(8'hCC, 0); send_byte(a, 0); send_byte(b, 0); send_byte(8'h03, 0);
    mem[0] = a; mem[1] = b;
    r = alu_fn(a, b, 4'h3);
    respond_alu(r, 0);
    wait_tx(2, 0);
    n_checks++;
    if (got_wr.size() != 2 || got_wr[0] !== {4'h0, a} || got_wr[1] !== {4'h1, b})
      $display("FAIL b2b_writes: got %0d writes required %h %h", got_wr.size(), {4'h0, a}, {4'h1, b});
    else n_pass++;
    n_checks++;
    if (got_tx.size() != 2 || got_tx[0] !== r[7:0] || got_tx[1] !== r[15:8])
      $display("FAIL b2b_tx: got %0d bytes required %h %h", got_tx.size(), r[7:0], r[15:8]);
    else n_pass++;
  endtask

  task automatic test_random();
    int          kind, g;
    logic [7:0]  a, b, f;
    logic [15:0] r;
    for (int it = 0; it < 40; it++) begin
      clear_q();
      kind = $urandom_range(0, 4);
      g = $urandom_range(0, 1);
      a = 8'($urandom); b = 8'($urandom); f = 8'($urandom);
      case (kind)
        0: begin
          send_byte(8'hAA, g); send_byte(a, g); send_byte(b, 1);
          exp_wr.push_back({a[3:0], b}); mem[a[3:0]] = b;
          repeat (3) tick();
        end
        1: begin
          send_byte(8'hBB, g); send_byte(a, 0);
          exp_rd.push_back(a[3:0]); exp_tx.push_back(mem[a[3:0]]);
          respond_read(mem[a[3:0]]);
          wait_tx(1, 1);
        end
        2: begin
          send_byte(8'hCC, g); send_byte(a, g); send_byte(b, g); send_byte(f, 0);
          mem[0] = a; mem[1] = b;
          exp_wr.push_back({4'h0, a}); exp_wr.push_back({4'h1, b});
          exp_alu.push_back(f[3:0]);
          r = alu_fn(a, b, f[3:0]);
          exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
          respond_alu(r, $urandom_range(0, 3));
          wait_tx(2, 1);
        end
        3: begin
          send_byte(8'hDD, g); send_byte(f, 0);
          exp_alu.push_back(f[3:0]);
          r = alu_fn(mem[0], mem[1], f[3:0]);
          exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
          respond_alu(r, $urandom_range(0, 3));
          wait_tx(2, 1);
        end
        default: begin
          send_byte(8'($urandom_range(0, 8'hA9)), 1);
          repeat (3) tick();
        end
      endcase
      n_checks++;
      if (got_wr.size() != exp_wr.size() || got_rd.size() != exp_rd.size() ||
          got_alu.size() != exp_alu.size() || got_tx.size() != exp_tx.size())
        $display("FAIL rand_counts it%0d kind%0d: got wr%0d rd%0d alu%0d tx%0d required wr%0d rd%0d alu%0d tx%0d",
                 it, kind, got_wr.size(), got_rd.size(), got_alu.size(), got_tx.size(),
                 exp_wr.size(), exp_rd.size(), exp_alu.size(), exp_tx.size());
      else n_pass++;
      foreach (exp_wr[i]) begin
        n_checks++;
        if (((i < got_wr.size()) ? got_wr[i] : 'x) !== exp_wr[i])
          $display("FAIL rand_wr it%0d: got %h required %h", it, (i < got_wr.size()) ? got_wr[i] : 'x, exp_wr[i]);
        else n_pass++;
      end
      foreach (exp_rd[i]) begin
        n_checks++;
        if (((i < got_rd.size()) ? got_rd[i] : 'x) !== exp_rd[i])
          $display("FAIL rand_rd it%0d: got %h required %h", it, (i < got_rd.size()) ? got_rd[i] : 'x, exp_rd[i]);
        else n_pass++;
      end
      foreach (exp_alu[i]) begin
        n_checks++;
        if (((i < got_alu.size()) ? got_alu[i] : 'x) !== exp_alu[i])
          $display("FAIL rand_alu it%0d: got %h required %h", it, (i < got_alu.size()) ? got_alu[i] : 'x, exp_alu[i]);
        else n_pass++;
      end
      foreach (exp_tx[i]) begin
        n_checks++;
        if (((i < got_tx.size()) ? got_tx[i] : 'x) !== exp_tx[i])
          $display("FAIL rand_tx it%0d: got %h required %h", it, (i < got_tx.size()) ? got_tx[i] : 'x, exp_tx[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (both_viol != 0) $display("FAIL wr_rd_overlap: got %0d cycles required 0", both_viol);
    else n_pass++;
    n_checks++;
    if (full_viol != 0) $display("FAIL tx_when_full: got %0d pushes required 0", full_viol);
    else n_pass++;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_fifo_full();
    test_invalid();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
